pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 170 +++++++++++++++++
 tb/tb_pipe_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Purpose  : Pipelined add / accumulate / clear unit with a ready/valid
//            handshake on both sides. The result is computed when an operation
//            is accepted and then carried through STAGES further register
//            stages, so it appears STAGES cycles after acceptance. The whole
//            pipe stalls while the output holds a result nobody takes.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready      - input handshake
//            a, b [WIDTH]             - operands
//            mode [2]                 - 00 add, 01 accumulate, 10 clear, 11 add
//            out_valid / out_ready    - output handshake
//            y [WIDTH+1], ovf         - result and overflow flag
//            txn_cnt [16]             - results delivered (wraps)
//            err                      - rejected-input pulse (ADDER_XCHECK_EN)
// Options  : ADDER_XCHECK_EN - when defined, accepted operations carrying X/Z
//            on a, b or mode are dropped and err pulses for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic             ovf,
`ifdef ADDER_XCHECK_EN
  output logic             err,
`endif
  output logic [15:0]      txn_cnt
);

  localparam logic [1:0] c_mode_acc = 2'b01;
  localparam logic [1:0] c_mode_clr = 2'b10;

  logic             advance_w;
  logic             accept_w;
  logic             res_vld_w;
  logic [WIDTH+1:0] acc_sum_w;
  logic [WIDTH:0]   res_y_w;
  logic             res_ovf_w;

  logic [WIDTH:0]   acc_d, acc_q;
  logic [STAGES:0]  vld_d, vld_q;
  logic [WIDTH:0]   sy_d [0:STAGES];
  logic [WIDTH:0]   sy_q [0:STAGES];
  logic [STAGES:0]  sovf_d, sovf_q;
  logic [15:0]      txn_cnt_d, txn_cnt_q;

  // Every stage moves together; a held output freezes the entire pipe.
  assign in_ready  = !vld_q[STAGES] || out_ready;
  assign advance_w = in_ready;
  assign accept_w  = in_valid && in_ready;
  assign acc_sum_w = {1'b0, acc_q} + {2'b00, a};

  // Result of the operation currently presented on the inputs.
  always_comb begin
    res_y_w   = '0;
    res_ovf_w = 1'b0;
    case (mode)
      c_mode_acc: begin
        res_ovf_w = acc_sum_w[WIDTH+1];
        if ((SAT != 0) && res_ovf_w) begin
          res_y_w = '1;
        end else begin
          res_y_w = acc_sum_w[WIDTH:0];
        end
      end
      c_mode_clr: begin
        res_y_w = '0;
      end
      default: begin
        // Add, and reserved mode 11 which aliases to add.
        res_y_w = {1'b0, a} + {1'b0, b};
      end
    endcase
  end

`ifdef ADDER_XCHECK_EN
  logic bad_w;
  logic err_d, err_q;

  assign bad_w     = $isunknown({a, b, mode});
  assign res_vld_w = accept_w && !bad_w;
  assign err_d     = accept_w && bad_w;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign res_vld_w = accept_w;
`endif

  // The accumulator takes the new value at acceptance so that back-to-back
  // accumulates chain without waiting for the pipe. Clear yields res_y_w = 0.
  always_comb begin
    acc_d = acc_q;
    if (res_vld_w && ((mode == c_mode_acc) || (mode == c_mode_clr))) begin
      acc_d = res_y_w;
    end
  end

  // Stage 0 captures the computed result; later stages only shift.
  always_comb begin
    vld_d  = vld_q;
    sovf_d = sovf_q;
    for (int i = 0; i <= STAGES; i++) begin
      sy_d[i] = sy_q[i];
    end
    if (advance_w) begin
      vld_d[0]  = res_vld_w;
      sy_d[0]   = res_y_w;
      sovf_d[0] = res_ovf_w;
      for (int i = 1; i <= STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        sy_d[i]   = sy_q[i-1];
        sovf_d[i] = sovf_q[i-1];
      end
    end
  end

  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (vld_q[STAGES] && out_ready) begin
      txn_cnt_d = txn_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      vld_q     <= '0;
      sovf_q    <= '0;
      txn_cnt_q <= '0;
      for (int i = 0; i <= STAGES; i++) begin
        sy_q[i] <= '0;
      end
    end else begin
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      sovf_q    <= sovf_d;
      txn_cnt_q <= txn_cnt_d;
      for (int i = 0; i <= STAGES; i++) begin
        sy_q[i] <= sy_d[i];
      end
    end
  end

  assign out_valid = vld_q[STAGES];
  assign y         = sy_q[STAGES];
  assign ovf       = sovf_q[STAGES];
  assign txn_cnt   = txn_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Purpose  : Directed self-checking bench for pipe_adder (WIDTH=3, STAGES=2).
//            A wrapping and a saturating instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] mode;

  logic        in_ready, out_valid, ovf;
  logic [3:0]  y;
  logic [15:0] txn_cnt;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [3:0]  s_y;
  logic [15:0] s_txn_cnt;
`ifdef ADDER_XCHECK_EN
  logic        err, s_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(3), .STAGES(2), .SAT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf),
`ifdef ADDER_XCHECK_EN
    .err(err),
`endif
    .txn_cnt(txn_cnt)
  );

  pipe_adder #(.WIDTH(3), .STAGES(2), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
    .y(s_y), .ovf(s_ovf),
`ifdef ADDER_XCHECK_EN
    .err(s_err),
`endif
    .txn_cnt(s_txn_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle, then wait until its result is
  // on the output (pipe assumed empty and out_ready high).
  task automatic run_op(input logic [2:0] av, input logic [2:0] bv, input logic [1:0] mv);
    a = av; b = bv; mode = mv; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
  endtask

  logic [2:0] st_a [4];
  logic [2:0] st_b [4];
  logic [3:0] st_y [4];

  initial begin
    int sent;
    int rcvd;
    logic do_acc;
    logic do_cons;

    st_a = '{3'd1, 3'd2, 3'd7, 3'd4};
    st_b = '{3'd1, 3'd3, 3'd7, 3'd0};
    st_y = '{4'd2, 4'd5, 4'd14, 4'd4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = 2'b00;

    // Reset state
    tick;
    tick;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Add 3+5 with latency check
    a = 3'd3; b = 3'd5; mode = 2'b00; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("add_lat_e0", 32'(out_valid), 32'd0);
    tick;
    check("add_lat_e1", 32'(out_valid), 32'd0);
    tick;
    check("add_lat_e2", 32'(out_valid), 32'd1);
    check("add_y", 32'(y), 32'd8);
    check("add_ovf", 32'(ovf), 32'd0);
    tick;
    check("add_txn", 32'(txn_cnt), 32'd1);
    check("add_drained", 32'(out_valid), 32'd0);

    // Three back-to-back accumulates of 7
    a = 3'd7; b = 3'd0; mode = 2'b01; in_valid = 1'b1;
    tick;
    tick;
    tick;
    in_valid = 1'b0;
    check("acc1_y", 32'(y), 32'd7);
    check("acc1_ovf", 32'(ovf), 32'd0);
    check("acc1_sat_y", 32'(s_y), 32'd7);
    tick;
    check("acc2_y", 32'(y), 32'd14);
    check("acc2_ovf", 32'(ovf), 32'd0);
    check("acc2_sat_y", 32'(s_y), 32'd14);
    tick;
    check("acc3_y", 32'(y), 32'd5);
    check("acc3_ovf", 32'(ovf), 32'd1);
    check("acc3_sat_y", 32'(s_y), 32'd15);
    check("acc3_sat_ovf", 32'(s_ovf), 32'd1);
    tick;

    // Clear, then confirm the accumulator restarts from zero
    run_op(3'd5, 3'd6, 2'b10);
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_y", 32'(y), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    tick;
    run_op(3'd3, 3'd0, 2'b01);
    check("acc_after_clr", 32'(y), 32'd3);
    check("sat_acc_after_clr", 32'(s_y), 32'd3);
    tick;

    // Reserved mode behaves as add
    run_op(3'd6, 3'd7, 2'b11);
    check("rsv_y", 32'(y), 32'd13);
    check("rsv_ovf", 32'(ovf), 32'd0);
    tick;

    // Fresh reset, then stream 4 adds with a 3-cycle output stall
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 30 && rcvd < 4; c++) begin
      in_valid = (sent < 4);
      if (sent < 4) begin
        a = st_a[sent]; b = st_b[sent]; mode = 2'b00;
      end
      out_ready = !(c >= 3 && c < 6);
      #1;
      if (out_valid) check("stream_y", 32'(y), 32'(st_y[rcvd]));
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      do_acc  = in_valid && in_ready;
      do_cons = out_valid && out_ready;
      tick;
      if (do_acc) sent++;
      if (do_cons) rcvd++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(rcvd), 32'd4);
    check("stream_txn", 32'(txn_cnt), 32'd4);

    // Reset with operations in flight and the output stalled
    out_ready = 1'b0;
    a = 3'd1; b = 3'd1; mode = 2'b00; in_valid = 1'b1;
    tick;
    a = 3'd2; b = 3'd2;
    tick;
    in_valid = 1'b0;
    tick;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_txn", 32'(txn_cnt), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      check("no_stale", 32'(out_valid), 32'd0);
    end

    // Acceptance resumes after reset
    run_op(3'd4, 3'd7, 2'b00);
    check("resume_y", 32'(y), 32'd11);
    check("resume_txn", 32'(txn_cnt), 32'd0);
    tick;
    check("resume_txn_after", 32'(txn_cnt), 32'd1);

`ifdef ADDER_XCHECK_EN
    // Seed acc = 1, then an X add and an X accumulate must be dropped
    run_op(3'd1, 3'd0, 2'b01);
    check("x_seed", 32'(y), 32'd1);
    tick;
    a = 3'b01x; b = 3'd0; mode = 2'b00; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    a = 3'd0;
    check("x_err_on", 32'(err), 32'd1);
    tick;
    check("x_err_off", 32'(err), 32'd0);
    check("x_no_valid1", 32'(out_valid), 32'd0);
    a = 3'bx01; mode = 2'b01; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("x_acc_err", 32'(err), 32'd1);
    tick;
    check("x_no_valid2", 32'(out_valid), 32'd0);
    tick;
    check("x_no_valid3", 32'(out_valid), 32'd0);
    run_op(3'd2, 3'd2, 2'b00);
    check("x_follow_y", 32'(y), 32'd4);
    tick;
    run_op(3'd0, 3'd0, 2'b01);
    check("x_acc_kept", 32'(y), 32'd1);
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
